// File: rtl/i2s_pcm_transmitter.sv
// I2S bus-master transmitter: serialises left/right PCM pairs onto sck/ws/sd with the one-bit I2S delay.
// Define I2S_TX_HOLD_LAST_EN to repeat the previous pair on underrun instead of sending zeros.
module i2s_pcm_transmitter #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int CLK_DIV        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUMBER_OF_BITS-1:0] sample_left,
  input  logic [NUMBER_OF_BITS-1:0] sample_right,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      sck,
  output logic                      ws,
  output logic                      sd,
  output logic                      underrun,
  output logic [7:0]                underrun_count
);

  localparam int N  = NUMBER_OF_BITS;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int KW = (N > 1) ? $clog2(2 * N) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(2 * N - 1);
  localparam logic [KW-1:0] K_RIGHT  = KW'(N);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic            alive;      // low during reset and for the first edge after it
  logic            full;
  logic [N-1:0]    hold_l;
  logic [N-1:0]    hold_r;
  logic [2*N-1:0]  shift;
  logic            last_bit;
  logic [DW-1:0]   div_cnt;
  logic [KW-1:0]   k;
`ifdef I2S_TX_HOLD_LAST_EN
  logic [2*N-1:0]  last_pair;
`endif

  logic          accept;
  logic          half_done;
  logic          boundary;
  logic [KW-1:0] k_next;

  assign sample_ready = alive & ~full;
  assign accept       = sample_valid & sample_ready;
  assign half_done    = (state == RUN) && (div_cnt == DIV_LAST);
  assign k_next       = k + 1'b1;
  // A frame starts either on leaving IDLE with a pair held, or when sck falls at the end of k = 2N-1.
  assign boundary     = ((state == IDLE) && full) || (half_done && sck && (k == K_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the holding register is reset along with the control state so a pair held at reset can never be transmitted.
      state          <= IDLE;
      alive          <= 1'b0;
      full           <= 1'b0;
      hold_l         <= '0;
      hold_r         <= '0;
      shift          <= '0;
      last_bit       <= 1'b0;
      div_cnt        <= '0;
      k              <= '0;
      sck            <= 1'b0;
      ws             <= 1'b0;
      sd             <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
`ifdef I2S_TX_HOLD_LAST_EN
      last_pair      <= '0;
`endif
    end else begin
      alive    <= 1'b1;
      underrun <= 1'b0;

      if (accept) begin
        hold_l <= sample_left;
        hold_r <= sample_right;
        full   <= 1'b1;
      end

      if (boundary) begin
        state   <= RUN;
        div_cnt <= '0;
        k       <= '0;
        sck     <= 1'b0;
        ws      <= 1'b0;
        sd      <= last_bit;
        if (full) begin
          shift    <= {hold_l, hold_r};
          last_bit <= hold_r[0];
          full     <= 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
          last_pair <= {hold_l, hold_r};
`endif
        end else begin
          underrun <= 1'b1;
          if (underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
`ifdef I2S_TX_HOLD_LAST_EN
          shift    <= last_pair;
          last_bit <= last_pair[0];
`else
          shift    <= '0;
          last_bit <= 1'b0;
`endif
        end
      end else if (state == RUN) begin
        if (half_done) begin
          div_cnt <= '0;
          sck     <= ~sck;
          // Data and word select move only on the falling sck edge.
          if (sck) begin
            k     <= k_next;
            ws    <= (k_next >= K_RIGHT);
            sd    <= shift[2*N-1];
            shift <= shift << 1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule
